if_fetch_unit: RTL and testbench
================================

// Module: if_fetch_unit
// PURPOSE
//   Instruction-fetch stage of the 5-stage MIPS pipeline. Owns the PC register.
//   Drives ce/addr into the combinational instruction ROM, and registers the returned
//   word with its PC into the IF/ID pipeline latch for decode.
//   Redirects on ID-stage branches (delay slot honoured), flushes on exceptions, and
//   holds or bubbles on pipeline stalls.
// PARAMETERS
//   RESET_PC   32'h0000_0000  first fetch address after reset
//   CNT_W      32             width of the delivered-instruction counter
// PORTS
//   clk              in   1      system clock, rising edge
//   rst              in   1      asynchronous, active-low reset (rst==0 resets)
//   stall_if         in   1      hold PC, no new fetch this cycle
//   stall_id         in   1      hold IF/ID latch contents
//   flush            in   1      exception/eret flush; redirect to new_pc
//   new_pc           in   32     flush target
//   branch_flag      in   1      ID resolved a taken branch/jump this cycle
//   branch_target    in   32     branch/jump target
//   inst_i           in   32     ROM data, valid same cycle as pc_o when ce_o=1
//   ce_o             out  1      ROM chip enable
//   pc_o             out  32     ROM fetch address (byte address)
//   id_pc            out  32     PC of instruction in IF/ID
//   id_inst          out  32     instruction in IF/ID (0 = NOP)
//   id_valid         out  1      IF/ID holds a real fetched instruction
//   align_err        out  1      1-cycle pulse: redirect target had [1:0]!=0
//   fetch_cnt        out  CNT_W  count of instructions delivered to ID, saturating
// BEHAVIOUR
//   Reset values: ce_o=0, pc_o=RESET_PC, id_pc=0, id_inst=0, id_valid=0,
//     align_err=0, fetch_cnt=0, state=S_BOOT.
//   States:
//     S_BOOT: ce_o=0, no fetch. The first posedge after rst deasserts sets ce_o=1
//       and moves to S_RUN. pc_o stays RESET_PC unless flush is high, in which
//       case it loads new_pc.
//     S_RUN: ce_o=1 permanently. Only rst leaves this state.
//   Next-PC priority in S_RUN, evaluated each posedge:
//     1. flush: pc_o<=new_pc.
//     2. stall_if: pc_o holds.
//     3. branch_flag: pc_o<=branch_target.
//     4. otherwise: pc_o<=pc_o+4, wrapping mod 2^32 (32'hFFFF_FFFC -> 0).
//   Redirect alignment: any loaded redirect target gets bits [1:0] forced to 00.
//     If the original target[1:0]!=0, align_err pulses the next cycle.
//   Delay slot: when branch_flag is seen, the word at the current pc_o is the
//     delay slot. It is captured into IF/ID normally in the same edge.
//   IF/ID latch priority, each posedge:
//     1. flush: id_inst=0, id_pc=0, id_valid=0.
//     2. stall_id: hold all fields.
//     3. stall_if with stall_id=0: bubble (id_inst=0, id_valid=0, id_pc holds).
//     4. otherwise: id_pc<=pc_o, id_inst<=inst_i, id_valid<=ce_o.
//   fetch_cnt increments on each edge in which rule 4 loads id_valid=1.
//     It saturates at all-ones and is cleared only by rst.
//   Fetch latency: word at pc_o appears on id_inst one edge later.
//     Branch penalty: 0 bubbles (delay slot). Flush penalty: 1 bubble.
//   Async reset mid-operation forces every output to its reset value immediately,
//     regardless of the clock. Fetch restarts from S_BOOT.
//   No combinational path from any input to ce_o/pc_o; all outputs registered.
// TESTING
//   1. Release reset, ROM word = addr: cycle1 ce_o=0, then pc_o 0,4,8 with
//      id_inst 0,4 one edge later; id_valid=1 from the 2nd edge of S_RUN.
//   2. branch_flag=1 with target 0x40 while pc_o=0x0C:
//      id_inst gets the 0x0C word (delay slot), then pc_o=0x40, then 0x44.
//   3. stall_if=1 and stall_id=1 for 3 cycles at pc_o=0x20: pc_o and IF/ID frozen.
//      Then stall_id=0 with stall_if=1: one bubble (id_valid=0).
//      Then on release, fetch resumes at 0x20.
//   4. flush, new_pc=0x180, asserted together with branch_flag and stall_if:
//      pc_o=0x180, IF/ID cleared, fetch_cnt unchanged that edge.
//   5. branch_target=0x103 -> pc_o=0x100, align_err high exactly one cycle.
//   6. pc_o=0xFFFF_FFFC wraps to 0. Preload fetch_cnt near max: saturates at all-ones.
//      Async rst mid-run: all outputs reset with no clock edge.

Source files
------------

// File: rtl/if_fetch_unit.sv
// ============================================================================
// if_fetch_unit
// ----------------------------------------------------------------------------
// Instruction-fetch stage of a 5-stage MIPS pipeline. This block owns the PC
// register, drives the chip enable and address of a combinational instruction
// ROM, and registers the returned word and its PC into the IF/ID latch.
//
// Redirects:
//   flush        exception/eret redirect to new_pc; clears IF/ID (1 bubble)
//   branch_flag  taken branch/jump resolved in ID; the word fetched in the
//                same cycle is the delay slot and is latched normally, so the
//                branch costs no bubble
// Any loaded redirect target is word-aligned by forcing bits [1:0] to 00. A
// misaligned target raises align_err for exactly one cycle.
//
// Ports:
//   clk            in   1      system clock, rising edge
//   rst            in   1      asynchronous active-low reset
//   stall_if       in   1      hold PC, no new fetch this cycle
//   stall_id       in   1      hold IF/ID latch contents
//   flush          in   1      exception/eret flush, redirect to new_pc
//   new_pc         in   32     flush target
//   branch_flag    in   1      ID resolved a taken branch/jump this cycle
//   branch_target  in   32     branch/jump target
//   inst_i         in   32     ROM data for pc_o, same cycle
//   ce_o           out  1      ROM chip enable
//   pc_o           out  32     ROM fetch address (byte address)
//   id_pc          out  32     PC of the instruction held in IF/ID
//   id_inst        out  32     instruction held in IF/ID (0 = NOP)
//   id_valid       out  1      IF/ID holds a real fetched instruction
//   align_err      out  1      one-cycle pulse on a misaligned redirect
//   fetch_cnt      out  CNT_W  saturating count of instructions given to ID
// ============================================================================
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall_if,
    input  logic             stall_id,
    input  logic             flush,
    input  logic [31:0]      new_pc,
    input  logic             branch_flag,
    input  logic [31:0]      branch_target,
    input  logic [31:0]      inst_i,
    output logic             ce_o,
    output logic [31:0]      pc_o,
    output logic [31:0]      id_pc,
    output logic [31:0]      id_inst,
    output logic             id_valid,
    output logic             align_err,
    output logic [CNT_W-1:0] fetch_cnt
);

    typedef enum logic {
        S_BOOT = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t           state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [31:0]      id_pc_q, id_pc_d;
    logic [31:0]      id_inst_q, id_inst_d;
    logic             id_valid_q, id_valid_d;
    logic             align_q, align_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             redirect;
    logic [31:0]      redirect_tgt;
    logic             deliver;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state. BOOT lasts exactly one edge; RUN is left only by rst.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_BOOT:  state_d = S_RUN;
            S_RUN:   state_d = S_RUN;
            default: state_d = S_BOOT;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs. The chip enable is a pure decode of the state register,
    // so there is no combinational path from any input to ce_o.
    // ------------------------------------------------------------------
    always_comb begin
        ce_o = (state_q == S_RUN);
    end

    // ------------------------------------------------------------------
    // Next PC. In BOOT only a flush may move the PC; stalls and branches
    // are ignored because nothing has been fetched yet.
    // ------------------------------------------------------------------
    always_comb begin
        pc_d         = pc_q;
        redirect     = 1'b0;
        redirect_tgt = new_pc;
        if (state_q == S_BOOT) begin
            if (flush) begin
                redirect     = 1'b1;
                redirect_tgt = new_pc;
            end
        end else if (flush) begin
            redirect     = 1'b1;
            redirect_tgt = new_pc;
        end else if (stall_if) begin
            pc_d = pc_q;
        end else if (branch_flag) begin
            redirect     = 1'b1;
            redirect_tgt = branch_target;
        end else begin
            // Natural 32-bit wrap: 32'hFFFF_FFFC + 4 = 0.
            pc_d = pc_q + 32'd4;
        end

        if (redirect) begin
            pc_d = {redirect_tgt[31:2], 2'b00};
        end
        align_d = redirect && (redirect_tgt[1:0] != 2'b00);
    end

    // ------------------------------------------------------------------
    // IF/ID latch. A stall_if without stall_id inserts a bubble but keeps
    // id_pc, so exception logic downstream still sees a sensible PC.
    // ------------------------------------------------------------------
    always_comb begin
        id_pc_d    = id_pc_q;
        id_inst_d  = id_inst_q;
        id_valid_d = id_valid_q;
        deliver    = 1'b0;
        if (flush) begin
            id_pc_d    = 32'd0;
            id_inst_d  = 32'd0;
            id_valid_d = 1'b0;
        end else if (stall_id) begin
            id_pc_d    = id_pc_q;
            id_inst_d  = id_inst_q;
            id_valid_d = id_valid_q;
        end else if (stall_if) begin
            id_inst_d  = 32'd0;
            id_valid_d = 1'b0;
        end else begin
            id_pc_d    = pc_q;
            id_inst_d  = inst_i;
            id_valid_d = ce_o;
            deliver    = ce_o;
        end
    end

    // Delivered-instruction counter, sticks at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (deliver && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q       <= RESET_PC;
            id_pc_q    <= 32'd0;
            id_inst_q  <= 32'd0;
            id_valid_q <= 1'b0;
            align_q    <= 1'b0;
            cnt_q      <= '0;
        end else begin
            pc_q       <= pc_d;
            id_pc_q    <= id_pc_d;
            id_inst_q  <= id_inst_d;
            id_valid_q <= id_valid_d;
            align_q    <= align_d;
            cnt_q      <= cnt_d;
        end
    end

    assign pc_o      = pc_q;
    assign id_pc     = id_pc_q;
    assign id_inst   = id_inst_q;
    assign id_valid  = id_valid_q;
    assign align_err = align_q;
    assign fetch_cnt = cnt_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// ============================================================================
// tb_if_fetch_unit
// ----------------------------------------------------------------------------
// Scoreboard bench for if_fetch_unit. Each cycle the reference model computes
// the state expected after the next rising edge and pushes it to a queue; one
// time unit after that edge the entry is popped and compared with the DUT.
// A second instance with a 3-bit counter shares all inputs so counter
// saturation is reached in a handful of deliveries.
// The ROM returns addr ^ 32'hC000_0000 so id_inst and id_pc are distinguishable.
// ============================================================================
module tb_if_fetch_unit;

    logic        clk;
    logic        rst;
    logic        stall_if, stall_id, flush, branch_flag;
    logic [31:0] new_pc, branch_target;
    wire  [31:0] inst_i;

    wire         ce_o, id_valid, align_err;
    wire  [31:0] pc_o, id_pc, id_inst, fetch_cnt;

    wire         s_ce, s_vld, s_align;
    wire  [31:0] s_pc, s_idpc, s_idinst;
    wire  [2:0]  s_cnt;

    int n_chk = 0;
    int n_err = 0;

    function automatic logic [31:0] rom(input logic [31:0] a);
        return a ^ 32'hC000_0000;
    endfunction

    assign inst_i = rom(pc_o);

    if_fetch_unit u_dut (
        .clk(clk), .rst(rst), .stall_if(stall_if), .stall_id(stall_id),
        .flush(flush), .new_pc(new_pc), .branch_flag(branch_flag),
        .branch_target(branch_target), .inst_i(inst_i), .ce_o(ce_o),
        .pc_o(pc_o), .id_pc(id_pc), .id_inst(id_inst), .id_valid(id_valid),
        .align_err(align_err), .fetch_cnt(fetch_cnt)
    );

    if_fetch_unit #(.RESET_PC(32'h0), .CNT_W(3)) u_sat (
        .clk(clk), .rst(rst), .stall_if(stall_if), .stall_id(stall_id),
        .flush(flush), .new_pc(new_pc), .branch_flag(branch_flag),
        .branch_target(branch_target), .inst_i(inst_i), .ce_o(s_ce),
        .pc_o(s_pc), .id_pc(s_idpc), .id_inst(s_idinst), .id_valid(s_vld),
        .align_err(s_align), .fetch_cnt(s_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state
    typedef struct packed {
        logic        ce;
        logic [31:0] pc;
        logic [31:0] idpc;
        logic [31:0] idinst;
        logic        idvld;
        logic        align;
        logic [31:0] cnt;
        logic [2:0]  cnt3;
    } exp_t;

    exp_t m;
    exp_t sb[$];

    task automatic model_reset();
        m = '0;
        sb.delete();
    endtask

    // Advance the model by one edge using the currently driven inputs.
    task automatic model_step();
        exp_t        n;
        logic [31:0] tgt;
        logic        take;
        n    = m;
        take = 1'b0;
        tgt  = 32'h0;
        // PC
        if (flush) begin
            take = 1'b1;
            tgt  = new_pc;
        end else if (m.ce && !stall_if && branch_flag) begin
            take = 1'b1;
            tgt  = branch_target;
        end else if (m.ce && !stall_if) begin
            n.pc = m.pc + 32'd4;
        end
        if (take) n.pc = tgt & 32'hFFFF_FFFC;
        n.align = take && (tgt[1:0] != 2'b00);
        // IF/ID
        if (flush) begin
            n.idpc = 0; n.idinst = 0; n.idvld = 0;
        end else if (!stall_id && stall_if) begin
            n.idinst = 0; n.idvld = 0;
        end else if (!stall_id) begin
            n.idpc   = m.pc;
            n.idinst = rom(m.pc);
            n.idvld  = m.ce;
            if (m.ce && m.cnt  != 32'hFFFF_FFFF) n.cnt  = m.cnt + 1;
            if (m.ce && m.cnt3 != 3'h7)          n.cnt3 = m.cnt3 + 3'd1;
        end
        n.ce = 1'b1;
        m = n;
    endtask

    task automatic tick();
        exp_t e;
        model_step();
        sb.push_back(m);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk_val("sb_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk_val("ce",       {31'd0, ce_o},      {31'd0, e.ce});
            chk_val("pc",       pc_o,               e.pc);
            chk_val("id_pc",    id_pc,              e.idpc);
            chk_val("id_inst",  id_inst,            e.idinst);
            chk_val("id_valid", {31'd0, id_valid},  {31'd0, e.idvld});
            chk_val("align",    {31'd0, align_err}, {31'd0, e.align});
            chk_val("cnt",      fetch_cnt,          e.cnt);
            chk_val("s_cnt",    {29'd0, s_cnt},     {29'd0, e.cnt3});
            chk_val("s_pc",     s_pc,               e.pc);
            chk_val("s_misc",   {s_idpc ^ s_idinst, 29'd0, s_ce, s_vld, s_align},
                                {e.idpc ^ e.idinst, 29'd0, e.ce, e.idvld, e.align});
        end
    endtask

    task automatic idle_inputs();
        stall_if = 0; stall_id = 0; flush = 0; branch_flag = 0;
        new_pc = 0; branch_target = 0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk_val({tag, "_ce"},    {31'd0, ce_o},      32'd0);
        chk_val({tag, "_pc"},    pc_o,               32'd0);
        chk_val({tag, "_idpc"},  id_pc,              32'd0);
        chk_val({tag, "_inst"},  id_inst,            32'd0);
        chk_val({tag, "_vld"},   {31'd0, id_valid},  32'd0);
        chk_val({tag, "_align"}, {31'd0, align_err}, 32'd0);
        chk_val({tag, "_cnt"},   fetch_cnt,          32'd0);
        chk_val({tag, "_scnt"},  {29'd0, s_cnt},     32'd0);
    endtask

    logic [31:0] cnt_before;

    initial begin
        rst = 0;
        idle_inputs();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs("rst");
        rst = 1;

        // Boot and sequential fetch
        tick();
        chk_val("t1_ce_after_boot", {31'd0, ce_o}, 32'd1);
        chk_val("t1_pc0", pc_o, 32'h0);
        tick();
        chk_val("t1_pc4", pc_o, 32'h4);
        chk_val("t1_inst0", id_inst, rom(32'h0));
        chk_val("t1_vld", {31'd0, id_valid}, 32'd1);
        tick();
        chk_val("t1_pc8", pc_o, 32'h8);
        chk_val("t1_inst4", id_inst, rom(32'h4));
        tick();

        // Branch with delay slot at 0x0C
        chk_val("t2_pcC", pc_o, 32'hC);
        branch_flag = 1; branch_target = 32'h40;
        tick();
        chk_val("t2_pc40", pc_o, 32'h40);
        chk_val("t2_delay_slot", id_inst, rom(32'hC));
        idle_inputs();
        tick();
        chk_val("t2_pc44", pc_o, 32'h44);
        chk_val("t2_inst40", id_inst, rom(32'h40));

        // Stalls at 0x20
        flush = 1; new_pc = 32'h20;
        tick();
        idle_inputs();
        stall_if = 1; stall_id = 1;
        repeat (3) tick();
        chk_val("t3_pc_frozen", pc_o, 32'h20);
        stall_id = 0;
        tick();
        chk_val("t3_bubble", {31'd0, id_valid}, 32'd0);
        chk_val("t3_pc_held", pc_o, 32'h20);
        idle_inputs();
        tick();
        chk_val("t3_resume_idpc", id_pc, 32'h20);
        chk_val("t3_resume_pc", pc_o, 32'h24);

        // Flush wins over branch and stall
        cnt_before = fetch_cnt;
        flush = 1; new_pc = 32'h180; branch_flag = 1; branch_target = 32'h40; stall_if = 1;
        tick();
        chk_val("t4_pc180", pc_o, 32'h180);
        chk_val("t4_clr_vld", {31'd0, id_valid}, 32'd0);
        chk_val("t4_cnt_hold", fetch_cnt, cnt_before);
        idle_inputs();
        tick();

        // Misaligned branch target
        branch_flag = 1; branch_target = 32'h103;
        tick();
        chk_val("t5_pc100", pc_o, 32'h100);
        chk_val("t5_align_hi", {31'd0, align_err}, 32'd1);
        idle_inputs();
        tick();
        chk_val("t5_align_lo", {31'd0, align_err}, 32'd0);

        // PC wrap
        flush = 1; new_pc = 32'hFFFF_FFF8;
        tick();
        idle_inputs();
        tick();
        chk_val("t6_pcFFC", pc_o, 32'hFFFF_FFFC);
        tick();
        chk_val("t6_wrap", pc_o, 32'h0);
        tick();
        chk_val("t6_sat3", {29'd0, s_cnt}, 32'd7);

        // Random traffic
        for (int i = 0; i < 60; i++) begin
            flush         = ($urandom_range(0, 7) == 0);
            stall_if      = ($urandom_range(0, 3) == 0);
            stall_id      = ($urandom_range(0, 4) == 0);
            branch_flag   = ($urandom_range(0, 3) == 0);
            new_pc        = $urandom;
            branch_target = $urandom;
            tick();
        end
        idle_inputs();
        tick();

        // Async reset between edges
        #2;
        rst = 0;
        #1;
        chk_reset_outputs("arst");
        model_reset();
        @(negedge clk);
        rst = 1;
        tick();
        tick();
        chk_val("arst_restart_pc", pc_o, 32'h4);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
